// File: rtl/rca_pkg.sv
// Shared types and helpers for the sequential multi-word ripple-carry adder.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chunk index width; a single-chunk build still gets a 1-bit counter.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module ripple_carry_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/rca_multiword_seq.sv
// Wide adder that reuses one N-bit ripple_carry_adder over WORDS cycles, LSB chunk first.
// Optional subtract mode (in_sub port) is enabled by defining RCA_SEQ_SUB_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// The producer holds valid and its payload until that edge; ready may be low at any time.
module rca_multiword_seq
  import rca_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic               in_sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic [1:0]         dbg_state_o
);

  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e                     state_q, state_d;
  logic [IW-1:0]              idx_q;
  logic                       carry_q;
  logic [WORDS-1:0][N-1:0]    a_q, b_q, sum_q;
  logic                       cout_q, ovf_q;

  logic [N-1:0]               rca_sum;
  logic                       rca_cout;
  logic [N*WORDS-1:0]         b_cap;
  logic                       cin_cap;

  ripple_carry_adder #(.N(N)) u_rca (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .cin_i  (carry_q),
    .sum_o  (rca_sum),
    .cout_o (rca_cout)
  );

  // Subtraction is A + ~B + 1, so B and the initial carry are conditioned at capture.
`ifdef RCA_SEQ_SUB_EN
  assign b_cap   = in_sub ? ~in_b : in_b;
  assign cin_cap = in_sub ? 1'b1 : in_cin;
`else
  assign b_cap   = in_b;
  assign cin_cap = in_cin;
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= b_cap;
            carry_q <= cin_cap;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q] <= rca_sum;
          carry_q      <= rca_cout;
          // Final chunk: the index parks at the last value instead of wrapping.
          if (idx_q == LAST_IDX) begin
            cout_q <= rca_cout;
            ovf_q  <= (a_q[WORDS-1][N-1] == b_q[WORDS-1][N-1]) &&
                      (rca_sum[N-1] != a_q[WORDS-1][N-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum     = sum_q;
  assign out_cout    = cout_q;
  assign out_ovf     = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rca_multiword_seq.sv
// Directed bench for rca_multiword_seq: vector table, back-pressure, reset abort, WORDS=1.
module tb_rca_multiword_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (N=8, WORDS=4) ----------------
  logic         in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [1:0]   dbg_state;

  rca_multiword_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
`ifdef RCA_SEQ_SUB_EN
    .in_sub      (in_sub),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_cout    (out_cout),
    .out_ovf     (out_ovf),
    .dbg_state_o (dbg_state)
  );

  // ---------------- single-chunk DUT (N=8, WORDS=1) ----------------
  logic       w1_in_valid, w1_in_ready, w1_in_cin, w1_in_sub;
  logic [7:0] w1_in_a, w1_in_b, w1_out_sum;
  logic       w1_out_valid, w1_out_ready, w1_out_cout, w1_out_ovf;
  logic [1:0] w1_dbg_state;

  rca_multiword_seq #(.N(8), .WORDS(1)) dut_w1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (w1_in_valid),
    .in_ready    (w1_in_ready),
    .in_a        (w1_in_a),
    .in_b        (w1_in_b),
    .in_cin      (w1_in_cin),
`ifdef RCA_SEQ_SUB_EN
    .in_sub      (w1_in_sub),
`endif
    .out_valid   (w1_out_valid),
    .out_ready   (w1_out_ready),
    .out_sum     (w1_out_sum),
    .out_cout    (w1_out_cout),
    .out_ovf     (w1_out_ovf),
    .dbg_state_o (w1_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int k;
    exp_q.push_back(es);
    @(negedge clk);
    check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
    check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    wait_out_valid(k);
    check({name, "_latency"}, k, WORDS);
    check({name, "_sum"}, out_sum, exp_q.pop_front());
    check({name, "_cout"}, 32'(out_cout), 32'(ec));
    check({name, "_ovf"}, 32'(out_ovf), 32'(eo));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k;
    vecs[0] = '{"wrap_all_ones", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{"pos_overflow",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{"mixed_cin",     32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h2143_6588, 1'b0, 1'b0};
    vecs[3] = '{"neg_overflow",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{"cin_only",      32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[5] = '{"max_plus_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{"chunk_ripple",  32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    w1_in_valid = 1'b0; w1_in_a = '0; w1_in_b = '0; w1_in_cin = 1'b0; w1_in_sub = 1'b0;
    w1_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", out_sum, 32'd0);
    check("rst_cout", 32'(out_cout), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].s, vecs[i].co, vecs[i].ov);

    // Back-pressure: hold DONE for 5 cycles while a new request is offered.
    @(negedge clk);
    in_a = 32'h1; in_b = 32'h2; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(k);
    check("bp_latency", k, WORDS);
    in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1111_1111;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum_hold", out_sum, 32'h3);
      check("bp_cout_hold", 32'(out_cout), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 check("bp_no_ghost_op", 32'(dbg_state), 32'd0);

    // Reset while RUN sits at idx=2: no result may appear afterwards.
    @(negedge clk);
    in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("abort_in_run", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_sum", out_sum, 32'd0);
    check("abort_cout", 32'(out_cout), 32'd0);
    check("abort_ovf", 32'(out_ovf), 32'd0);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) k++;
    end
    check("abort_no_emit", k, 0);
    do_op("after_abort", 32'hCAFE_0001, 32'h0001_FFFF, 1'b0, 1'b0, 32'hCB00_0000, 1'b0, 1'b0);

`ifdef RCA_SEQ_SUB_EN
    do_op("sub_5_7",     32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("sub_min_1",   32'h8000_0000, 32'd1,         1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

    // Single-chunk build: RUN lasts one cycle.
    @(negedge clk);
    check("w1_in_ready", 32'(w1_in_ready), 32'd1);
    w1_in_a = 8'hFF; w1_in_b = 8'h01; w1_in_cin = 1'b0; w1_in_valid = 1'b1;
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
    check("w1_not_yet", 32'(w1_out_valid), 32'd0);
    @(posedge clk); #1;
    check("w1_latency", 32'(w1_out_valid), 32'd1);
    check("w1_sum", 32'(w1_out_sum), 32'h00);
    check("w1_cout", 32'(w1_out_cout), 32'd1);
    check("w1_ovf", 32'(w1_out_ovf), 32'd0);
    w1_out_ready = 1'b1;
    @(posedge clk); #1;
    w1_out_ready = 1'b0;
    check("w1_release", 32'(w1_out_valid), 32'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
